// File: rtl/pp_shift_accumulator.sv
// Bit-serial shift-accumulator that turns AND-array partial products into a signed dot product.
// Optional ReLU early termination is enabled with the EARLY_TERM_EN macro.
module pp_shift_accumulator #(
  parameter int N     = 32,
  parameter int A     = 16,
  parameter int W     = 8,
  parameter int ACC_W = A + $clog2(N) + W,
  localparam int SW   = A + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*A-1:0]          pp_data_i,
  input  logic                    pp_valid_i,
  output logic                    pp_ready_o,
  input  logic [SW-1:0]           act_sum_i,
  output logic signed [ACC_W-1:0] res_data_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic                    res_early_o
);

  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE,
    SKIP
  } state_e;

  state_e                    state_q;
  logic [KW-1:0]             k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   res_q;
  logic                      ready_q;
  logic                      valid_q;
  logic                      early_q;

  logic [SW-1:0]             s;
  logic signed [ACC_W-1:0]   s_ext;
  logic signed [ACC_W-1:0]   acc_d;
  logic [KW-1:0]             k_d;
  logic                      fire;
  logic                      last;
  logic                      early_hit;

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + SW'(pp_data_i[i*A +: A]);
    end
  end

  assign s_ext = $signed({{(ACC_W-SW){1'b0}}, s});
  assign fire  = pp_valid_i & ready_q;

  // The sign beat carries weight -2^(W-1), so it seeds the accumulator negated.
  assign acc_d = (state_q == IDLE) ? -s_ext : (acc_q <<< 1) + s_ext;
  assign k_d   = (state_q == IDLE) ? KW'(1) : k_q + KW'(1);
  assign last  = (k_d == KW'(W));

`ifdef EARLY_TERM_EN
  logic [SW-1:0]           asum_q;
  logic [SW-1:0]           asum_d;
  logic signed [ACC_W-1:0] bound;

  assign asum_d    = (state_q == IDLE) ? act_sum_i : asum_q;
  assign bound     = acc_d + $signed({{(ACC_W-SW){1'b0}}, asum_d});
  assign early_hit = !last && (bound[ACC_W-1] || (bound == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asum_q <= '0;
    end else if (fire && state_q == IDLE) begin
      asum_q <= act_sum_i;
    end
  end
`else
  logic unused_act_sum;

  assign unused_act_sum = ^act_sum_i;
  assign early_hit      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      early_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          ready_q <= 1'b1;
          if (fire) begin
            acc_q <= acc_d;
            k_q   <= k_d;
            if (last || early_hit) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              res_q   <= early_hit ? '0 : acc_d;
              early_q <= early_hit;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            early_q <= 1'b0;
            ready_q <= 1'b1;
            if (k_q == KW'(W)) begin
              state_q <= IDLE;
              k_q     <= '0;
            end else begin
              state_q <= SKIP;
            end
          end
        end
        SKIP: begin
          ready_q <= 1'b1;
          // Outstanding beats are swallowed so the next sign beat lines up.
          if (fire) begin
            if (k_q + KW'(1) == KW'(W)) begin
              state_q <= IDLE;
              k_q     <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pp_ready_o  = ready_q;
  assign res_valid_o = valid_q;
  assign res_data_o  = res_q;
  assign res_early_o = early_q;

endmodule
